// File: rtl/vga_bw_framebuffer.sv
// One-bit-per-pixel frame buffer feeding the black/white VGA timing stage.
// Two-cycle display read pipeline, host byte-write port and a whole-buffer clear engine.
//
// state       | meaning
// ST_IDLE     | waiting for CLEAR or a host write request
// ST_ACK      | committing (or discarding) the host byte, WR_ACK high
// ST_CLEARING | filling one byte per cycle with the latched clear value
module vga_bw_framebuffer #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 16
) (
    input  logic              i_clock_pixel,
    input  logic              i_reset,
    input  logic [10:0]       i_pixel_h,
    input  logic [10:0]       i_pixel_v,
    output logic              o_pixel,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_clear,
    input  logic              i_clear_value,
    output logic              o_busy
);
    localparam int BYTES_PER_LINE = H_ACTIVE / 8;
    localparam int DEPTH          = BYTES_PER_LINE * V_ACTIVE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [10:0]       H_LIM     = 11'(H_ACTIVE);
    localparam logic [10:0]       V_LIM     = 11'(V_ACTIVE);

    typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_CLEARING} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [ADDR_W-1:0] w_clr_addr_nxt;
    logic              r_clr_value;
    logic              w_clr_value_nxt;

    logic [7:0]        r_mem [DEPTH];
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [7:0]        w_wdata;

    logic              w_in_range;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [2:0]        r_bit_sel0;
    logic [2:0]        r_bit_sel1;
    logic              r_in_range0;
    logic              r_in_range1;
    logic [7:0]        r_rd_data;
    logic              r_pixel;

    // Out-of-range coordinates are steered to byte 0 so the RAM is never overrun.
    assign w_in_range = (i_pixel_h < H_LIM) && (i_pixel_v < V_LIM);
    assign w_rd_addr  = w_in_range
                      ? ADDR_W'(i_pixel_v) * ADDR_W'(BYTES_PER_LINE) + ADDR_W'(i_pixel_h[10:3])
                      : '0;

    always_ff @(posedge i_clock_pixel or posedge i_reset) begin
        if (i_reset) begin
            r_rd_addr   <= '0;
            r_bit_sel0  <= '0;
            r_in_range0 <= 1'b0;
            r_bit_sel1  <= '0;
            r_in_range1 <= 1'b0;
            r_pixel     <= 1'b0;
        end else begin
            r_rd_addr   <= w_rd_addr;
            r_bit_sel0  <= ~i_pixel_h[2:0];
            r_in_range0 <= w_in_range;
            r_bit_sel1  <= r_bit_sel0;
            r_in_range1 <= r_in_range0;
            r_pixel     <= r_in_range1 ? r_rd_data[r_bit_sel1] : 1'b0;
        end
    end

    // RAM and its read register stay unreset so the array maps onto block RAM;
    // r_in_range1 masks the read data until the pipeline has refilled.
    always_ff @(posedge i_clock_pixel) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_rd_data <= r_mem[r_rd_addr];
    end

    always_ff @(posedge i_clock_pixel or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_clr_addr  <= '0;
            r_clr_value <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_addr  <= w_clr_addr_nxt;
            r_clr_value <= w_clr_value_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_clr_addr_nxt  = r_clr_addr;
        w_clr_value_nxt = r_clr_value;
        w_we            = 1'b0;
        w_waddr         = i_wr_addr;
        w_wdata         = i_wr_data;
        case (r_state)
            ST_IDLE: begin
                if (i_clear) begin
                    w_clr_value_nxt = i_clear_value;
                    w_clr_addr_nxt  = '0;
                    w_state_nxt     = ST_CLEARING;
                end else if (i_wr_req) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_we        = (i_wr_addr <= LAST_ADDR);
                w_state_nxt = ST_IDLE;
            end
            ST_CLEARING: begin
                w_we           = 1'b1;
                w_waddr        = r_clr_addr;
                w_wdata        = {8{r_clr_value}};
                w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_pixel  = r_pixel;
    assign o_wr_ack = (r_state == ST_ACK);
    assign o_busy   = (r_state == ST_CLEARING);
endmodule

// File: tb/tb_vga_bw_framebuffer.sv
// Randomized bench for vga_bw_framebuffer: a byte-array image model predicts PIXEL,
// and a per-cycle compare checks PIXEL, BUSY and WR_ACK; literal probes pin key pixels.
module tb_vga_bw_framebuffer;
    localparam int H   = 800;
    localparam int V   = 480;
    localparam int BPL = H / 8;
    localparam int N   = BPL * V;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] pix_h = '0;
    logic [10:0] pix_v = '0;
    logic        o_pixel;
    logic        wr_req = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ack;
    logic        clear = 1'b0;
    logic        clear_value = 1'b0;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem_m [N];
    bit         known [N];
    bit         exp_busy = 1'b0;
    bit         exp_ack  = 1'b0;
    bit         chk_on   = 1'b0;
    bit         e_val [3];
    bit         e_ok  [3];
    logic [10:0] mh, mv;
    bit         mrst;
    bit         tmp_ok, tmp_val;

    always #5 clk = ~clk;

    vga_bw_framebuffer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(16)) dut (
        .i_clock_pixel (clk),
        .i_reset       (rst),
        .i_pixel_h     (pix_h),
        .i_pixel_v     (pix_v),
        .o_pixel       (o_pixel),
        .i_wr_req      (wr_req),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .o_wr_ack      (wr_ack),
        .i_clear       (clear),
        .i_clear_value (clear_value),
        .o_busy        (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Pixel as seen by the display: white/black from the image, 0 outside the active area.
    function automatic bit model_pix(input int h, input int v, output bit ok);
        int a;
        ok = 1'b1;
        if (h >= H || v >= V) return 1'b0;
        a  = v * BPL + h / 8;
        ok = known[a];
        return mem_m[a][7 - h % 8];
    endfunction

    // Expectation for the coordinate sampled at each edge, delivered two edges later.
    always @(posedge clk) begin
        mh   = pix_h;
        mv   = pix_v;
        mrst = rst;
        #2;
        if (rst || mrst) begin
            for (int i = 0; i < 3; i++) begin
                e_val[i] = 1'b0;
                e_ok[i]  = 1'b1;
            end
        end else begin
            tmp_val  = model_pix(int'(mh), int'(mv), tmp_ok);
            e_val[2] = e_val[1]; e_ok[2] = e_ok[1];
            e_val[1] = e_val[0]; e_ok[1] = e_ok[0];
            e_val[0] = tmp_val;  e_ok[0] = tmp_ok;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", int'(busy), int'(exp_busy));
            chk("wr_ack", int'(wr_ack), int'(exp_ack));
            if (e_ok[2]) chk("pixel", int'(o_pixel), int'(e_val[2]));
        end
    end

    task automatic step();
        int r;
        @(posedge clk);
        #1;
        r = $urandom_range(0, 19);
        if (r < 5) begin
            pix_h = 11'($urandom_range(0, H - 1));
            pix_v = 11'($urandom_range(0, 3));
        end else if (r < 15) begin
            pix_h = 11'($urandom_range(0, H - 1));
            pix_v = 11'($urandom_range(0, V - 1));
        end else if (r < 17) begin
            pix_h = 11'($urandom_range(H, 2047));
            pix_v = 11'($urandom_range(0, 2047));
        end else if (r < 19) begin
            pix_h = 11'($urandom_range(0, 2047));
            pix_v = 11'($urandom_range(V, 2047));
        end else begin
            pix_h = 11'h7FF;
            pix_v = 11'h7FF;
        end
    endtask

    task automatic probe(input int h, input int v, input int expb, input string name);
        pix_h = 11'(h);
        pix_v = 11'(v);
        step();
        step();
        step();
        chk(name, int'(o_pixel), expb);
    endtask

    // Write FSM must be idle on entry; returns in the idle cycle after the commit.
    task automatic host_write(input int addr, input int data, input bit clr_in_ack);
        wr_req  = 1'b1;
        wr_addr = 16'(addr);
        wr_data = 8'(data);
        step();
        exp_ack = 1'b1;
        wr_req  = 1'b0;
        if (clr_in_ack) begin
            clear       = 1'b1;
            clear_value = 1'($urandom_range(0, 1));
        end
        step();
        exp_ack = 1'b0;
        clear   = 1'b0;
        if (addr < N) begin
            mem_m[addr] = 8'(data);
            known[addr] = 1'b1;
        end
    endtask

    initial begin
        int busy_cnt;
        int r, a;

        step();
        chk_on = 1'b1;
        repeat (3) step();
        chk("rst_pixel", int'(o_pixel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ack", int'(wr_ack), 0);
        rst = 1'b0;
        repeat (20) step();

        // Clear to white with a write request arriving in the same cycle;
        // a second CLEAR mid-fill must be ignored.
        clear = 1'b1; clear_value = 1'b1;
        wr_req = 1'b1; wr_addr = 16'd5; wr_data = 8'h5A;
        step();
        exp_busy = 1'b1;
        clear    = 1'b0;
        busy_cnt = int'(busy);
        for (int i = 0; i < N; i++) begin
            step();
            mem_m[i] = 8'hFF;
            known[i] = 1'b1;
            if (i == N - 1) exp_busy = 1'b0;
            if (i == 100) begin clear = 1'b1; clear_value = 1'b0; end
            if (i == 101) clear = 1'b0;
            busy_cnt += int'(busy);
        end
        chk("clear_len", busy_cnt, N);
        step();
        exp_ack = 1'b1;
        wr_req  = 1'b0;
        step();
        exp_ack  = 1'b0;
        mem_m[5] = 8'h5A;
        probe(41, 0, 1, "after_clear_41_0");
        probe(40, 0, 0, "after_clear_40_0");
        probe(1, 0, 1, "fill_1_0");
        probe(799, 479, 1, "fill_799_479");

        host_write(0, 'h80, 1'b0);
        host_write(N - 1, 'h01, 1'b0);
        probe(0, 0, 1, "px_0_0");
        probe(1, 0, 0, "px_1_0");
        probe(799, 479, 1, "px_799_479");
        probe(798, 479, 0, "px_798_479");

        host_write(N, 'hFF, 1'b0);
        probe(799, 479, 1, "oob_wr_799_479");
        probe(798, 479, 0, "oob_wr_798_479");

        probe(800, 0, 0, "oob_800_0");
        probe(0, 480, 0, "oob_0_480");
        probe(2047, 2047, 0, "oob_2047_2047");

        // Black clear aborted by reset after 1000 bytes.
        clear = 1'b1; clear_value = 1'b0;
        step();
        exp_busy = 1'b1;
        clear    = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            mem_m[i] = 8'h00;
        end
        rst      = 1'b1;
        exp_busy = 1'b0;
        #1;
        chk("busy_on_reset", int'(busy), 0);
        step();
        step();
        rst = 1'b0;
        probe(0, 0, 0, "partial_0_0");
        probe(799, 9, 0, "partial_799_9");
        probe(0, 10, 1, "partial_0_10");
        probe(799, 479, 1, "partial_799_479");

        host_write(1000, 'h0F, 1'b0);
        probe(3, 10, 0, "post_rst_3_10");
        probe(4, 10, 1, "post_rst_4_10");

        // WR_REQ held through WR_ACK starts a second write.
        wr_req = 1'b1; wr_addr = 16'd200; wr_data = 8'hFF;
        step();
        exp_ack = 1'b1;
        step();
        exp_ack    = 1'b0;
        mem_m[200] = 8'hFF;
        wr_data    = 8'h00;
        step();
        exp_ack = 1'b1;
        wr_req  = 1'b0;
        step();
        exp_ack    = 1'b0;
        mem_m[200] = 8'h00;
        probe(0, 2, 0, "b2b_0_2");

        repeat (600) begin
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 6)      a = $urandom_range(0, 4 * BPL - 1);
                else if (r < 9) a = $urandom_range(0, N - 1);
                else            a = $urandom_range(N, 65535);
                host_write(a, $urandom_range(0, 255), $urandom_range(0, 7) == 0);
            end else begin
                step();
            end
        end
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_bw_framebuffer.md
# vga_bw_framebuffer

One-bit-per-pixel frame buffer that sits directly upstream of the black/white VGA timing stage in the 800x480 buffered display path. On every pixel clock it takes the stage's PIXEL_H/PIXEL_V coordinates and returns that pixel's stored bit on PIXEL. A host-side byte write port with a request/acknowledge handshake updates the image. A built-in clear engine fills the whole buffer with a constant.

## Interface
- H_ACTIVE, 800: visible pixels per line; must be a multiple of 8.
- V_ACTIVE, 480: visible lines per frame.
- ADDR_W, 16: byte address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE/8.
- CLOCK_PIXEL input 1: pixel clock; the only clock.
- RESET input 1: asynchronous, active-high reset.
- PIXEL_H input 11: horizontal coordinate from the timing stage.
- PIXEL_V input 11: vertical coordinate from the timing stage.
- PIXEL output 1: stored bit for the coordinate presented two cycles earlier; 1 = white.
- WR_REQ input 1: host write request; held high until WR_ACK.
- WR_ADDR input ADDR_W: byte address = line*(H_ACTIVE/8) + column_byte.
- WR_DATA input 8: eight pixels; bit 7 = leftmost (h%8 == 0).
- WR_ACK output 1: one-cycle pulse; the write is complete or discarded.
- CLEAR input 1: one-cycle pulse that starts a fill of the whole buffer.
- CLEAR_VALUE input 1: fill bit, sampled on the CLEAR cycle.
- BUSY output 1: high while a clear runs.

## Operation
- Storage: dual-port RAM, H_ACTIVE*V_ACTIVE/8 bytes (48000 at defaults). One port is read-only for display; the other is write-only for host and clear writes.
- Read pipeline, running every cycle:
  - S0: byte_addr = PIXEL_V*(H_ACTIVE/8) + PIXEL_H[10:3] and bit_sel = 7 - PIXEL_H[2:0] are registered.
  - S0 also registers in_range = (PIXEL_H < H_ACTIVE) && (PIXEL_V < V_ACTIVE).
  - S1: RAM read.
  - S2: PIXEL <= in_range ? byte[bit_sel] : 0.
- Out-of-range coordinates (for example H=800 or V=480, which the timing stage emits at the porch edge) return 0 and never address the RAM beyond its last byte.
- Write FSM states:
  - IDLE: if CLEAR, latch CLEAR_VALUE, set clr_addr=0, go to CLEARING. Else if WR_REQ, go to ACK.
  - ACK: if WR_ADDR < H_ACTIVE*V_ACTIVE/8, write WR_DATA to WR_ADDR; otherwise discard. Pulse WR_ACK, go to IDLE.
  - CLEARING: write {8{value}} to clr_addr each cycle and increment. After the last byte is written, go to IDLE. BUSY = (state == CLEARING).
- Priority: CLEAR wins over a simultaneous WR_REQ. The request stays pending and is served after the clear.
- CLEAR during CLEARING or ACK is ignored; it is not queued.
- WR_REQ stays unacknowledged throughout a clear; the host just waits.
- Same-address read/write in one cycle: the read returns the old data.
- Reset mid-clear or mid-write aborts immediately. RAM contents are not reset, so a partial clear persists.

## Timing
- Reset values: PIXEL=0, WR_ACK=0, BUSY=0, FSM=IDLE, all pipeline registers 0 and in_range=0.
- Display latency is exactly 2 cycles from coordinate to PIXEL, with no gaps or stalls at any point. Integration compensates for it in the timing stage.
- Host write latency: WR_REQ sampled high in IDLE, then WR_ACK pulses on the next cycle. A write takes 2 cycles.
- WR_REQ still high in the cycle after WR_ACK starts a new write. The host must drop it for single writes.
- Clear duration: BUSY rises the cycle after CLEAR and stays high for exactly H_ACTIVE*V_ACTIVE/8 cycles (48000 at defaults).
- A new image appears on the display no earlier than 3 cycles after the write commits.

## Test plan
- Reset then an idle scan of full frames: PIXEL=0, BUSY=0 and WR_ACK=0 out of reset. After CLEAR with CLEAR_VALUE=1, PIXEL=1 for all h<800, v<480 and 0 elsewhere.
- Write 0x80 to address 0 and 0x01 to address 47999:
  - PIXEL=1 at (0,0) and (799,479).
  - PIXEL=0 at (1,0) and (798,479).
  - Each appears 2 cycles after the coordinate.
- WR_REQ asserted with CLEAR in the same cycle: BUSY high for 48000 cycles, then WR_ACK pulses and the written byte overrides the fill.
- WR_ADDR=48000 with WR_DATA=0xFF: WR_ACK pulses, no pixel changes, and (799,479) is unchanged.
- Coordinates (800,0), (0,480) and (2047,2047): PIXEL=0 with no RAM access out of range.
- RESET asserted at clear cycle 1000: BUSY=0 immediately. Bytes 0..999 are filled and byte 1000 onward keeps its old contents. A subsequent write is acknowledged normally.
